// File: rtl/mpp_signal_detector.sv
// mpp_signal_detector
// Slices a signed MPP sample stream with hysteresis, measures the spacing of
// rising edges in valid samples, and locks onto either the beacon or the
// digital-LF tone once enough consecutive periods fall inside the tolerance
// window of one class. A long silence (counter saturating) drops any lock.

module mpp_signal_detector #(
    parameter int HYST          = 960,
    parameter int BEACON_PERIOD = 39,
    parameter int LF_PERIOD     = 22,
    parameter int TOL           = 2,
    parameter int LOCK_CNT      = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_valid,
    input  logic signed [23:0] sample_in,
    output logic               period_valid,
    output logic [7:0]         period_out,
    output logic               beacon_detect,
    output logic               digital_lf_detect
);

    typedef enum logic [2:0] {
        SEARCH,
        CAND_B,
        CAND_L,
        LOCK_B,
        LOCK_L
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_B,
        CLS_L
    } class_t;

    localparam logic signed [23:0] POS_TH = 24'(HYST);
    localparam logic signed [23:0] NEG_TH = 24'(-HYST);
    localparam int B_LO = BEACON_PERIOD - TOL;
    localparam int B_HI = BEACON_PERIOD + TOL;
    localparam int L_LO = LF_PERIOD - TOL;
    localparam int L_HI = LF_PERIOD + TOL;
    localparam logic [1:0] LOCK_M = 2'(LOCK_CNT);
    localparam logic DIRECT_LOCK = (LOCK_CNT <= 1);

    logic       polarity;
    logic       pol_next;
    logic [7:0] cnt;
    logic [7:0] cnt_inc;
    logic       armed;
    logic       rise;
    logic       measure;
    logic       timeout;
    int         p_int;
    logic       is_b;
    logic       is_l;
    class_t     cls;
    state_t     state;
    state_t     state_next;
    logic [1:0] m;
    logic [1:0] m_next;
    logic [1:0] m_inc;

    // Hysteresis slicer: only a clear excursion past either threshold flips polarity.
    always_comb begin
        pol_next = polarity;
        if (sample_in >= POS_TH) begin
            pol_next = 1'b1;
        end else if (sample_in <= NEG_TH) begin
            pol_next = 1'b0;
        end
    end

    assign rise    = sample_valid && !polarity && pol_next;
    assign cnt_inc = (cnt == 8'd255) ? 8'd255 : cnt + 8'd1;
    assign measure = rise && armed;
    assign timeout = sample_valid && !rise && (cnt_inc == 8'd255);
    assign m_inc   = m + 2'd1;

    // The candidate period is the saturated sample count up to and including this edge.
    assign p_int = {24'd0, cnt_inc};
    assign is_b  = (p_int >= B_LO) && (p_int <= B_HI);
    assign is_l  = (p_int >= L_LO) && (p_int <= L_HI);

    // Period classification; beacon wins when both windows overlap.
    always_comb begin
        cls = CLS_NONE;
        if (is_b) begin
            cls = CLS_B;
        end else if (is_l) begin
            cls = CLS_L;
        end
    end

    // Lock FSM next state: only a measured period or a timeout moves it.
    always_comb begin
        state_next = state;
        m_next     = m;
        if (timeout) begin
            state_next = SEARCH;
            m_next     = 2'd0;
        end else if (measure) begin
            case (state)
                SEARCH: begin
                    if (cls == CLS_B) begin
                        m_next     = 2'd1;
                        state_next = DIRECT_LOCK ? LOCK_B : CAND_B;
                    end else if (cls == CLS_L) begin
                        m_next     = 2'd1;
                        state_next = DIRECT_LOCK ? LOCK_L : CAND_L;
                    end
                end
                CAND_B: begin
                    if (cls == CLS_B) begin
                        m_next = m_inc;
                        if (m_inc == LOCK_M) begin
                            state_next = LOCK_B;
                        end
                    end else if (cls == CLS_L) begin
                        m_next     = 2'd1;
                        state_next = CAND_L;
                    end else begin
                        m_next     = 2'd0;
                        state_next = SEARCH;
                    end
                end
                CAND_L: begin
                    if (cls == CLS_L) begin
                        m_next = m_inc;
                        if (m_inc == LOCK_M) begin
                            state_next = LOCK_L;
                        end
                    end else if (cls == CLS_B) begin
                        m_next     = 2'd1;
                        state_next = CAND_B;
                    end else begin
                        m_next     = 2'd0;
                        state_next = SEARCH;
                    end
                end
                LOCK_B: begin
                    if (cls != CLS_B) begin
                        m_next     = 2'd0;
                        state_next = SEARCH;
                    end
                end
                LOCK_L: begin
                    if (cls != CLS_L) begin
                        m_next     = 2'd0;
                        state_next = SEARCH;
                    end
                end
                default: begin
                    m_next     = 2'd0;
                    state_next = SEARCH;
                end
            endcase
        end
    end

    // Lock state register; detect flags are registered from the next state so they
    // change on the same edge that launches the matching period pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= SEARCH;
            m                 <= 2'd0;
            beacon_detect     <= 1'b0;
            digital_lf_detect <= 1'b0;
        end else begin
            state             <= state_next;
            m                 <= m_next;
            beacon_detect     <= (state_next == LOCK_B);
            digital_lf_detect <= (state_next == LOCK_L);
        end
    end

    // Slicer, edge counter, arming and period capture, all gated by sample_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            polarity     <= 1'b0;
            cnt          <= 8'd0;
            armed        <= 1'b0;
            period_valid <= 1'b0;
            period_out   <= 8'd0;
        end else begin
            period_valid <= 1'b0;
            if (sample_valid) begin
                polarity <= pol_next;
                cnt      <= rise ? 8'd0 : cnt_inc;
                if (rise) begin
                    armed <= 1'b1;
                end else if (timeout) begin
                    armed <= 1'b0;
                end
                if (measure) begin
                    period_out   <= cnt_inc;
                    period_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mpp_signal_detector.sv
// tb_mpp_signal_detector
// Drives directed beacon, digital-LF and square-wave streams into the detector
// and checks every clock against a period/run-length model, plus literal
// expectations for pulse periods, pulse positions and lock/unlock positions.

module tb_mpp_signal_detector;

    localparam int HYST     = 960;
    localparam int BP       = 39;
    localparam int LP       = 22;
    localparam int TOL      = 2;
    localparam int LOCK_CNT = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               sample_valid = 1'b0;
    logic signed [23:0] sample_in = '0;
    logic               period_valid;
    logic [7:0]         period_out;
    logic               beacon_detect;
    logic               digital_lf_detect;

    bit clkEn = 1'b0;
    int passCount = 0;
    int checkCount = 0;

    // model state
    bit mPol;
    bit mArmed;
    int mSince;
    int runCls;
    int runLen;
    int sidx;
    int lastIdx;
    bit expPv;
    int expPeriod;
    bit expB;
    bit expL;

    // observation logs
    int dutPer[$];
    int dutIdx[$];
    int mPer[$];
    int bRise[$];
    int bFall[$];
    int lRise[$];
    bit prevB;
    bit prevL;

    int rampDn[8] = '{1500, 1000, 500, 0, -500, -1000, -1500, -1800};
    int rampUp[9] = '{-1440, -480, 1000, 1200, 1400, 1600, 1700, 1800, 1900};

    mpp_signal_detector #(
        .HYST(HYST), .BEACON_PERIOD(BP), .LF_PERIOD(LP), .TOL(TOL), .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_valid(sample_valid),
        .sample_in(sample_in),
        .period_valid(period_valid),
        .period_out(period_out),
        .beacon_detect(beacon_detect),
        .digital_lf_detect(digital_lf_detect)
    );

    always #5 begin
        if (clkEn) clk = ~clk;
    end

    task automatic checkVal(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic checkList(input string name, input int got[$], input int want[$]);
        checkVal($sformatf("%s count", name), got.size(), want.size());
        for (int i = 0; i < want.size() && i < got.size(); i++)
            checkVal($sformatf("%s[%0d]", name, i), got[i], want[i]);
    endtask

    function automatic int classify(input int p);
        int db = (p > BP) ? p - BP : BP - p;
        int dl = (p > LP) ? p - LP : LP - p;
        if (db <= TOL) return 1;
        if (dl <= TOL) return 2;
        return 0;
    endfunction

    task automatic resetModel();
        mPol = 0; mArmed = 0; mSince = 0; runCls = 0; runLen = 0;
        sidx = 0; lastIdx = -1; expPv = 0; expPeriod = 0; expB = 0; expL = 0;
        dutPer.delete(); dutIdx.delete(); mPer.delete();
        bRise.delete(); bFall.delete(); lRise.delete();
        prevB = 0; prevL = 0;
    endtask

    // One valid sample: edges are spaced in valid samples; a run of same-class
    // periods of length LOCK_CNT locks; any other period while locked, or 255
    // samples of silence, throws the run away.
    task automatic modelStep(input int s);
        bit newPol = mPol;
        int p;
        int cls;
        if (s >= HYST) newPol = 1;
        else if (s <= -HYST) newPol = 0;
        expPv = 0;
        if (newPol && !mPol) begin
            if (mArmed) begin
                p = (mSince + 1 > 255) ? 255 : mSince + 1;
                expPeriod = p;
                expPv = 1;
                mPer.push_back(p);
                cls = classify(p);
                if (runLen >= LOCK_CNT) begin
                    if (cls != runCls) begin runLen = 0; runCls = 0; end
                end else if (cls == 0) begin
                    runLen = 0; runCls = 0;
                end else if (cls == runCls) begin
                    runLen++;
                end else begin
                    runCls = cls; runLen = 1;
                end
            end
            mArmed = 1;
            mSince = 0;
        end else begin
            mSince = (mSince + 1 > 255) ? 255 : mSince + 1;
            if (mSince == 255) begin
                mArmed = 0; runLen = 0; runCls = 0;
            end
        end
        mPol = newPol;
        expB = (runLen >= LOCK_CNT) && (runCls == 1);
        expL = (runLen >= LOCK_CNT) && (runCls == 2);
        lastIdx = sidx;
        sidx++;
    endtask

    task automatic checkOutput();
        checkVal("period_valid", int'(period_valid), int'(expPv));
        checkVal("period_out", int'(period_out), expPeriod);
        checkVal("beacon_detect", int'(beacon_detect), int'(expB));
        checkVal("digital_lf_detect", int'(digital_lf_detect), int'(expL));
        if (period_valid) begin
            dutPer.push_back(int'(period_out));
            dutIdx.push_back(lastIdx);
        end
        if (beacon_detect && !prevB) bRise.push_back(lastIdx);
        if (!beacon_detect && prevB) bFall.push_back(lastIdx);
        if (digital_lf_detect && !prevL) lRise.push_back(lastIdx);
        prevB = beacon_detect;
        prevL = digital_lf_detect;
    endtask

    // compare process: model advances on the edge, outputs checked 1 time unit later
    always @(posedge clk) begin
        if (!rst) begin
            if (sample_valid) modelStep(int'(sample_in));
            else expPv = 0;
            #1;
            if (!rst) checkOutput();
        end
    end

    task automatic applyStimulus(input bit v, input int s);
        @(negedge clk);
        sample_valid = v;
        sample_in = 24'(s);
    endtask

    // asynchronous reset between edges; outputs must clear without a clock edge
    task automatic doReset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        sample_valid = 1'b0;
        resetModel();
        #1;
        checkVal("rst period_valid", int'(period_valid), 0);
        checkVal("rst period_out", int'(period_out), 0);
        checkVal("rst beacon_detect", int'(beacon_detect), 0);
        checkVal("rst digital_lf_detect", int'(digital_lf_detect), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int beaconSample(input int ph);
        if (ph < 8) return 1920;
        if (ph < 16) return rampDn[ph - 8];
        if (ph < 30) return -1920;
        return rampUp[ph - 30];
    endfunction

    function automatic int lfSample(input int ph);
        case (ph)
            4:  return 1100;
            5:  return -300;
            6:  return -1600;
            15: return -1600;
            16: return -300;
            17: return 1100;
            default: return (ph >= 7 && ph <= 14) ? -1920 : 1920;
        endcase
    endfunction

    task automatic runBeacon(input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            if (toggle) applyStimulus(1'b0, -beaconSample(i % BP));
            applyStimulus(1'b1, beaconSample(i % BP));
        end
    endtask

    task automatic runSquare(input int per, input int cycles);
        for (int c = 0; c < cycles; c++)
            for (int k = 0; k < per; k++)
                applyStimulus(1'b1, (k < per / 2) ? 1920 : -1920);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0);
    endtask

    initial begin
        int want[$];
        int wantIdx[$];
        resetModel();

        // reset with no clock running
        #1 rst = 1'b1;
        #2;
        checkVal("power-up period_valid", int'(period_valid), 0);
        checkVal("power-up period_out", int'(period_out), 0);
        checkVal("power-up beacon_detect", int'(beacon_detect), 0);
        checkVal("power-up digital_lf_detect", int'(digital_lf_detect), 0);
        clkEn = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // beacon stream up to the lock edge, then silence until timeout
        runBeacon(150, 1'b0);
        for (int i = 0; i < 260; i++) applyStimulus(1'b1, 0);
        idle(2);
        want = {32, 39, 39, 39};
        wantIdx = {32, 71, 110, 149};
        checkList("beacon periods", dutPer, want);
        checkList("beacon model periods", mPer, want);
        checkList("beacon pulse idx", dutIdx, wantIdx);
        checkVal("beacon lock idx", (bRise.size() > 0) ? bRise[0] : -1, 149);
        checkVal("beacon timeout idx", (bFall.size() > 0) ? bFall[0] : -1, 404);
        checkVal("beacon lf rises", lRise.size(), 0);

        // digital-LF stream
        doReset();
        for (int i = 0; i < 84; i++) applyStimulus(1'b1, lfSample(i % LP));
        idle(2);
        want = {17, 22, 22, 22};
        wantIdx = {17, 39, 61, 83};
        checkList("lf periods", dutPer, want);
        checkList("lf pulse idx", dutIdx, wantIdx);
        checkVal("lf lock idx", (lRise.size() > 0) ? lRise[0] : -1, 83);
        checkVal("lf beacon rises", bRise.size(), 0);

        // beacon with sample_valid toggling, then reset while locked
        doReset();
        runBeacon(150, 1'b1);
        idle(2);
        want = {32, 39, 39, 39};
        wantIdx = {32, 71, 110, 149};
        checkList("gapped periods", dutPer, want);
        checkList("gapped pulse idx", dutIdx, wantIdx);
        checkVal("gapped lock idx", (bRise.size() > 0) ? bRise[0] : -1, 149);
        checkVal("pre-reset beacon_detect", int'(beacon_detect), 1);
        doReset();

        // period 42 square wave never locks
        runSquare(42, 6);
        idle(2);
        checkVal("sq42 pulses", dutPer.size(), 5);
        checkVal("sq42 beacon rises", bRise.size(), 0);
        checkVal("sq42 lf rises", lRise.size(), 0);

        // period 41 locks; a single 42 drops lock, then it relocks
        doReset();
        runSquare(41, 5);
        runSquare(42, 1);
        runSquare(41, 4);
        idle(2);
        want = {41, 41, 41, 41, 41, 42, 41, 41, 41};
        checkList("sq41 periods", dutPer, want);
        wantIdx = {123, 370};
        checkList("sq41 lock idx", bRise, wantIdx);
        wantIdx = {247};
        checkList("sq41 drop idx", bFall, wantIdx);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
